// File: rtl/i4001_rom.sv
// ---------------------------------------------------------------------------
// i4001_rom -- one MCS-4 program ROM chip with its 4-bit I/O port.
//
// Follows the i4004 8-phase instruction cycle (A1 A2 A3 M1 M2 X1 X2 X3)
// using the CPU sync strobe. It captures the 12-bit address a nibble at a
// time from the CPU data bus. When the chip number in A3 matches, it returns
// the addressed byte as two nibbles in M1 and M2. It also decodes SRC chip
// selection and the WRR / RDR port instructions.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   sync       CPU sync, high during X3
//   cm_rom     CPU ROM command line
//   dbus_in    CPU-to-memory data bus nibble
//   dbus_out   memory-to-CPU data bus nibble (0 when not driving)
//   dbus_oe    dbus_out is valid and must be merged onto the bus
//   prog_we    program-load write strobe
//   prog_addr  program-load byte address
//   prog_data  program-load byte
//   io_in      external port inputs, returned by RDR
//   io_out     port output latch, written by WRR
// ---------------------------------------------------------------------------
module i4001_rom #(
    parameter logic [3:0] CHIP_ID   = 4'h0,
    parameter string      INIT_FILE = ""
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sync,
    input  logic       cm_rom,
    input  logic [3:0] dbus_in,
    output logic [3:0] dbus_out,
    output logic       dbus_oe,
    input  logic       prog_we,
    input  logic [7:0] prog_addr,
    input  logic [7:0] prog_data,
    input  logic [3:0] io_in,
    output logic [3:0] io_out
);

    typedef enum logic [3:0] {
        PH_UNSYNC,
        PH_A1,
        PH_A2,
        PH_A3,
        PH_M1,
        PH_M2,
        PH_X1,
        PH_X2,
        PH_X3
    } phase_t;

    localparam logic [3:0] OPA_WRR = 4'h2;
    localparam logic [3:0] OPA_RDR = 4'hA;

    phase_t     phase_reg;
    phase_t     phase_next;

    logic [3:0] addr_lo_reg;
    logic [3:0] addr_hi_reg;
    logic       selected_reg;
    logic       io_instr_reg;
    logic [3:0] opa_reg;
    logic       src_sel_reg;
    logic [3:0] io_out_reg;
    logic [7:0] rom_q_reg;

    logic [7:0] mem [0:255];

    // A sync seen anywhere other than X3 aborts the cycle in progress.
    logic       resync;
    logic       wrr_hit;
    logic       rdr_hit;

    assign resync  = sync && (phase_reg != PH_X3);
    assign wrr_hit = io_instr_reg && (opa_reg == OPA_WRR) && src_sel_reg;
    assign rdr_hit = io_instr_reg && (opa_reg == OPA_RDR) && src_sel_reg;

    // -----------------------------------------------------------------------
    // Array contents: zero at elaboration, never touched by reset.
    // -----------------------------------------------------------------------
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h00;
        end
    end

    // -----------------------------------------------------------------------
    // Phase sequencing
    // -----------------------------------------------------------------------
    always_comb begin
        phase_next = phase_reg;
        if (sync) begin
            phase_next = PH_A1;
        end else begin
            case (phase_reg)
                PH_UNSYNC: phase_next = PH_UNSYNC;
                PH_A1:     phase_next = PH_A2;
                PH_A2:     phase_next = PH_A3;
                PH_A3:     phase_next = PH_M1;
                PH_M1:     phase_next = PH_M2;
                PH_M2:     phase_next = PH_X1;
                PH_X1:     phase_next = PH_X2;
                PH_X2:     phase_next = PH_X3;
                PH_X3:     phase_next = PH_A1;
                default:   phase_next = PH_UNSYNC;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Control state: address capture, chip match, I/O decode, port latch
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg    <= PH_UNSYNC;
            addr_lo_reg  <= 4'h0;
            addr_hi_reg  <= 4'h0;
            selected_reg <= 1'b0;
            io_instr_reg <= 1'b0;
            opa_reg      <= 4'h0;
            src_sel_reg  <= 1'b0;
            io_out_reg   <= 4'h0;
        end else begin
            phase_reg <= phase_next;

            case (phase_reg)
                PH_A1: addr_lo_reg  <= dbus_in;
                PH_A2: addr_hi_reg  <= dbus_in;
                PH_A3: selected_reg <= cm_rom && (dbus_in == CHIP_ID);
                PH_M1: io_instr_reg <= cm_rom;
                PH_M2: opa_reg      <= dbus_in;
                PH_X2: begin
                    // An aborted cycle must not alter port or SRC state.
                    if (!sync) begin
                        if (cm_rom && !io_instr_reg) begin
                            src_sel_reg <= (dbus_in == CHIP_ID);
                        end
                        if (wrr_hit) begin
                            io_out_reg <= dbus_in;
                        end
                    end
                end
                default: ;
            endcase

            // Clearing on resync takes priority over the captures above, so
            // a sync landing in A3 or M1 cannot leave a stale drive armed.
            if (resync) begin
                selected_reg <= 1'b0;
                io_instr_reg <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Program array: write port for program load, registered read issued at
    // the end of A3 for every cycle. A read and a write to the same address
    // in the same clock return the old byte.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
        if (phase_reg == PH_A3) begin
            rom_q_reg <= mem[{addr_hi_reg, addr_lo_reg}];
        end
    end

    // -----------------------------------------------------------------------
    // Bus drive: only M1/M2 (instruction return) and X2 (RDR) ever drive,
    // so at most one nibble source is active in any phase.
    // -----------------------------------------------------------------------
    always_comb begin
        dbus_out = 4'h0;
        dbus_oe  = 1'b0;
        case (phase_reg)
            PH_M1: begin
                if (selected_reg) begin
                    dbus_out = rom_q_reg[7:4];
                    dbus_oe  = 1'b1;
                end
            end
            PH_M2: begin
                if (selected_reg) begin
                    dbus_out = rom_q_reg[3:0];
                    dbus_oe  = 1'b1;
                end
            end
            PH_X2: begin
                if (rdr_hit) begin
                    dbus_out = io_in;
                    dbus_oe  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign io_out = io_out_reg;

endmodule

// File: tb/tb_i4001_rom.sv
module tb_i4001_rom;

    localparam logic [3:0] CHIP = 4'h2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sync;
    logic       cm_rom;
    logic [3:0] dbus_in;
    logic [3:0] dbus_out;
    logic       dbus_oe;
    logic       prog_we;
    logic [7:0] prog_addr;
    logic [7:0] prog_data;
    logic [3:0] io_in;
    logic [3:0] io_out;

    int n_pass  = 0;
    int n_total = 0;

    // Expected outputs for the current phase, plus the bench's own view of
    // chip state: program bytes, SRC selection and the port latch.
    logic       chk_en = 1'b0;
    logic       exp_oe;
    logic [3:0] exp_out;
    logic [3:0] exp_io;
    int         cur_p = -1;
    logic [3:0] got_m1, got_m2, got_x2;
    logic [7:0] mem_m [256];
    logic       src_m;
    logic [3:0] io_m;

    always #5 clk = ~clk;

    i4001_rom #(.CHIP_ID(CHIP), .INIT_FILE("")) dut (
        .clk(clk), .rst_n(rst_n), .sync(sync), .cm_rom(cm_rom),
        .dbus_in(dbus_in), .dbus_out(dbus_out), .dbus_oe(dbus_oe),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .io_in(io_in), .io_out(io_out)
    );

    function automatic void check(string name, logic [7:0] act, logic [7:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s phase=%0d t=%0t: got %0h required %0h", name, cur_p, $time, act, expv);
    endfunction

    // Compare process: every negedge, away from the sampling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("dbus_oe", {7'b0, dbus_oe}, {7'b0, exp_oe});
            check("dbus_out", {4'b0, dbus_out}, {4'b0, exp_out});
            check("io_out", {4'b0, io_out}, {4'b0, exp_io});
            if (cur_p == 3) got_m1 = dbus_out;
            if (cur_p == 4) got_m2 = dbus_out;
            if (cur_p == 6) got_x2 = dbus_out;
        end
    end

    task automatic idle_expect();
        cur_p   = -1;
        exp_oe  = 1'b0;
        exp_out = 4'h0;
        exp_io  = io_m;
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        mem_m[a] = d;
        idle_expect();
        @(posedge clk); #1;
        prog_we = 1'b0;
    endtask

    task automatic sync_start();
        @(posedge clk); #1;
        sync = 1'b1; cm_rom = 1'b0; dbus_in = 4'h0;
        idle_expect();
    endtask

    // One full CPU instruction cycle. abort_at pulses sync in that phase,
    // rst_at pulls reset low in that phase; both end the cycle early.
    task automatic cpu_cycle(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3,
                             input logic cm_a3, input logic cm_m1, input logic [3:0] m2_d,
                             input logic cm_x2, input logic [3:0] x2_d,
                             input int abort_at, input int rst_at,
                             input logic pw, input logic [7:0] pw_data);
        logic       sel;
        logic       rdr;
        logic [7:0] byte_q;
        sel    = cm_a3 && (a3 == CHIP);
        rdr    = cm_m1 && (m2_d == 4'hA) && src_m;
        byte_q = 8'h00;
        for (int p = 0; p < 8; p++) begin
            @(posedge clk); #1;
            if (p == 7) begin
                // Effects of the end of X2.
                if (cm_x2 && !cm_m1) src_m = (x2_d == CHIP);
                if (cm_m1 && m2_d == 4'h2 && src_m) io_m = x2_d;
            end
            prog_we = 1'b0;
            sync    = (p == 7) || (p == abort_at);
            cm_rom  = 1'b0;
            dbus_in = 4'h0;
            case (p)
                0: dbus_in = a1;
                1: dbus_in = a2;
                2: begin
                    dbus_in = a3;
                    cm_rom  = cm_a3;
                    byte_q  = mem_m[{a2, a1}];
                    if (pw) begin
                        prog_we   = 1'b1;
                        prog_addr = {a2, a1};
                        prog_data = pw_data;
                        mem_m[{a2, a1}] = pw_data;
                    end
                end
                3: cm_rom = cm_m1;
                4: dbus_in = m2_d;
                6: begin dbus_in = x2_d; cm_rom = cm_x2; end
                default: ;
            endcase
            cur_p   = p;
            exp_oe  = 1'b0;
            exp_out = 4'h0;
            if (p == 3 && sel) begin exp_oe = 1'b1; exp_out = byte_q[7:4]; end
            if (p == 4 && sel) begin exp_oe = 1'b1; exp_out = byte_q[3:0]; end
            if (p == 6 && rdr) begin exp_oe = 1'b1; exp_out = io_in; end
            exp_io = io_m;
            if (p == rst_at) begin
                #2;
                rst_n = 1'b0;
                sync  = 1'b0;
                io_m  = 4'h0;
                src_m = 1'b0;
                idle_expect();
                return;
            end
            if (p == abort_at) return;
        end
    endtask

    initial begin
        rst_n = 1'b1; sync = 1'b0; cm_rom = 1'b0; dbus_in = 4'h0; io_in = 4'h0;
        prog_we = 1'b0; prog_addr = 8'h00; prog_data = 8'h00;
        got_m1 = 4'h0; got_m2 = 4'h0; got_x2 = 4'h0;
        src_m = 1'b0; io_m = 4'h0;
        for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
        idle_expect();

        // Reset state.
        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Program load while unsynchronised.
        load(8'h35, 8'hD7);
        load(8'h12, 8'h3C);
        load(8'h47, 8'h96);

        // No bus activity before the first sync, even with a matching A3.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            cm_rom = 1'b1; dbus_in = 4'(i + 1);
        end

        sync_start();

        // Basic fetch of 0x35 (chip 2).
        cpu_cycle(4'h5, 4'h3, CHIP, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, -1, -1, 1'b0, 8'h00);
        check("lit_fetch_hi", {4'b0, got_m1}, 8'h0D);
        check("lit_fetch_lo", {4'b0, got_m2}, 8'h07);

        // Chip mismatch, then match with another address.
        cpu_cycle(4'h5, 4'h3, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, -1, -1, 1'b0, 8'h00);
        cpu_cycle(4'h2, 4'h1, CHIP, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, -1, -1, 1'b0, 8'h00);
        check("lit_fetch2_hi", {4'b0, got_m1}, 8'h03);
        check("lit_fetch2_lo", {4'b0, got_m2}, 8'h0C);

        // SRC selects chip 2, WRR writes 9.
        cpu_cycle(4'h7, 4'h4, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, CHIP, -1, -1, 1'b0, 8'h00);
        cpu_cycle(4'h7, 4'h4, 4'h0, 1'b0, 1'b1, 4'h2, 1'b0, 4'h9, -1, -1, 1'b0, 8'h00);
        check("lit_wrr", {4'b0, io_out}, 8'h09);

        // SRC selects chip 3: WRR ignored.
        cpu_cycle(4'h7, 4'h4, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 4'h3, -1, -1, 1'b0, 8'h00);
        cpu_cycle(4'h7, 4'h4, 4'h0, 1'b0, 1'b1, 4'h2, 1'b0, 4'h5, -1, -1, 1'b0, 8'h00);
        check("lit_wrr_unsel", {4'b0, io_out}, 8'h09);

        // RDR after reselecting.
        io_in = 4'hC;
        cpu_cycle(4'h7, 4'h4, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, CHIP, -1, -1, 1'b0, 8'h00);
        cpu_cycle(4'h7, 4'h4, 4'h0, 1'b0, 1'b1, 4'hA, 1'b0, 4'h0, -1, -1, 1'b0, 8'h00);
        check("lit_rdr", {4'b0, got_x2}, 8'h0C);

        // Resync during M1 of a selected fetch, then a normal fetch.
        cpu_cycle(4'h5, 4'h3, CHIP, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 3, -1, 1'b0, 8'h00);
        cpu_cycle(4'h2, 4'h1, CHIP, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, -1, -1, 1'b0, 8'h00);
        check("lit_resync_lo", {4'b0, got_m2}, 8'h0C);

        // Write during the A3 read: old byte now, new byte next time.
        cpu_cycle(4'h5, 4'h3, CHIP, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, -1, -1, 1'b1, 8'h5A);
        check("lit_rbw_hi", {4'b0, got_m1}, 8'h0D);
        check("lit_rbw_lo", {4'b0, got_m2}, 8'h07);
        cpu_cycle(4'h5, 4'h3, CHIP, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, -1, -1, 1'b0, 8'h00);
        check("lit_new_hi", {4'b0, got_m1}, 8'h05);
        check("lit_new_lo", {4'b0, got_m2}, 8'h0A);

        // Reset during M2 of a selected fetch; outputs drop before next edge.
        cpu_cycle(4'h5, 4'h3, CHIP, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, -1, 4, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        sync_start();
        cpu_cycle(4'h2, 4'h1, CHIP, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, -1, -1, 1'b0, 8'h00);
        check("lit_after_rst_hi", {4'b0, got_m1}, 8'h03);

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
